status_valid_queue: RTL and testbench
=====================================

# status_valid_queue

Parametrised, out-of-order-completion status queue: entries are allocated in order at the tail, their status value is written later by tag in any order, and they retire strictly in order from the head once completed. It generalises the single-bit status valid vector to multi-bit values, tag-addressed updates, occupancy reporting and flush. It sits between an issue stage, which allocates entries, and a retire stage, which drains completed entries oldest-first.

## Interface
- DEPTH, 16, number of entries; power of two, >= 2
- WIDTH, 1, status value width in bits
- AW, clog2(DEPTH), tag width (derived, not overridden)
- clk_i  input  1  clock, rising edge
- rsn_i  input  1  reset; one clock; reset is asynchronous and active-low
- push_i  input  1  allocate an entry at the tail
- push_value_i  input  WIDTH  initial status value of the allocated entry
- alloc_tag_o  output  AW  tag of the next slot to allocate (tail pointer)
- upd_i  input  1  write a completion
- upd_tag_i  input  AW  slot being completed
- upd_value_i  input  WIDTH  completion value
- upd_err_o  output  1  one-cycle pulse: previous-cycle update targeted a non-allocated slot
- pull_i  input  1  retire the head entry
- valid_o  output  1  head entry is allocated and completed
- head_value_o  output  WIDTH  status value of the head entry
- flush_i  input  1  discard all entries
- full_o  output  1  count == DEPTH
- empty_o  output  1  count == 0
- count_o  output  AW+1  number of allocated entries

## Operation
- Per slot state: alloc bit, done bit, value[WIDTH]. Pointers head_q, tail_q (AW bits, wrap modulo DEPTH), count_q (AW+1 bits).
- Push accepted iff push_i & ~full_o: slot[tail] <= {alloc=1, done=0, value=push_value_i}; tail += 1.
- Pull accepted iff pull_i & valid_o: slot[head].alloc <= 0, done <= 0; head += 1. Pull while ~valid_o is ignored.
- Update: if slot[upd_tag_i].alloc is set in pre-edge state, value <= upd_value_i, done <= 1. Otherwise ignored and upd_err_o asserts the next cycle.
- Repeated update to an already-done slot overwrites the value; no error.
- count_q += push_acc - pull_acc. Simultaneous push and pull when full: push rejected, because full_o is evaluated pre-edge. Simultaneous push and pull when 0 < count < DEPTH: count unchanged.
- Update to head tag in the same cycle as an accepted pull: slot is freed, write dropped, no error.
- Update to tail tag in the same cycle as an accepted push: slot is not pre-allocated, so the update is dropped, upd_err_o pulses, and the push initial value is written.
- Flush has priority over all other inputs: all alloc/done bits <= 0, head = tail = 0, count = 0. upd_err_o is not raised for an update in the flush cycle.

## Timing
- All state updates on the rising edge of clk_i. No input-to-output combinational paths.
- valid_o, head_value_o, full_o, empty_o, count_o, alloc_tag_o are combinational from registers only.
- upd_err_o is registered, asserting 1 cycle after the offending update.
- Latency: push at edge N → entry visible in count_o after N. Update at edge N → valid_o rises after N if the entry is at the head.
- Throughput: one push, one update and one pull per cycle.
- Reset (asynchronous, at any time, including mid-operation) clears all slots and pointers. Reset values: valid_o 0, head_value_o 0, full_o 0, empty_o 1, count_o 0, alloc_tag_o 0, upd_err_o 0. Slot values also reset to 0.

## Structure
- Package status_valid_pkg holds the clog2 function and the slot state fields/width constants shared with future variants.
- Sub-module status_valid_slot: one per entry, instanced via generate. Inputs: alloc_set, free, upd_hit, push_value, upd_value, flush. Outputs: alloc, done, value.
- Top level holds the pointers, count, accept logic, head mux and error register.

## Test plan
All scenarios use DEPTH=4, WIDTH=8.
- Reset then idle → empty_o=1, full_o=0, count_o=0, alloc_tag_o=0, valid_o=0.
- Push values 0x11,0x22,0x33,0x44 (tags 0..3) → full_o=1, count_o=4. Fifth push is ignored and count stays 4.
- Out-of-order completion: update tag2=0xC2, then tag0=0xA0 → valid_o=1, head_value_o=0xA0. Pull → head=tag1 and valid_o=0 until tag1 is updated with 0xB1.
- Wrap-around: continuous push+pull with immediate completion for 10 cycles → tags cycle 0,1,2,3,0…, retired values appear in push order, count stays constant.
- Boundary collisions: update to a free slot → upd_err_o=1 for exactly one cycle. Update to head in the same cycle as its pull → no error and no state change to the freed slot. Push+pull while full → push rejected, count_o=3.
- Flush with 3 entries, and separately rsn_i low mid-burst → next cycle empty_o=1, count_o=0, alloc_tag_o=0, valid_o=0.

Source files
------------

// File: rtl/status_valid_queue_pkg.sv
// Shared definitions for the status valid queue family: slot control bit
// layout and the tag-width helper.
package status_valid_pkg;

  localparam int unsigned SLOT_ALLOC_BIT = 0;
  localparam int unsigned SLOT_DONE_BIT  = 1;
  localparam int unsigned SLOT_CTRL_W    = 2;

  function automatic int unsigned sv_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/status_valid_queue_if.sv
// Issue/update/retire bundle between the pipeline stages and the status queue.
interface status_valid_queue_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 1
);
  import status_valid_pkg::*;
  localparam int unsigned AW = sv_clog2(DEPTH);

  logic             push_i;
  logic [WIDTH-1:0] push_value_i;
  logic [AW-1:0]    alloc_tag_o;
  logic             upd_i;
  logic [AW-1:0]    upd_tag_i;
  logic [WIDTH-1:0] upd_value_i;
  logic             upd_err_o;
  logic             pull_i;
  logic             valid_o;
  logic [WIDTH-1:0] head_value_o;
  logic             flush_i;
  logic             full_o;
  logic             empty_o;
  logic [AW:0]      count_o;

  modport slave (
    input  push_i, push_value_i, upd_i, upd_tag_i, upd_value_i, pull_i, flush_i,
    output alloc_tag_o, upd_err_o, valid_o, head_value_o, full_o, empty_o, count_o
  );

  modport master (
    output push_i, push_value_i, upd_i, upd_tag_i, upd_value_i, pull_i, flush_i,
    input  alloc_tag_o, upd_err_o, valid_o, head_value_o, full_o, empty_o, count_o
  );

endinterface

// File: rtl/status_valid_queue_slot.sv
// One queue entry: alloc/done control bits plus the status value.
module status_valid_slot
  import status_valid_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             alloc_set,
  input  logic             free,
  input  logic             upd_hit,
  input  logic [WIDTH-1:0] push_value,
  input  logic [WIDTH-1:0] upd_value,
  input  logic             flush,
  output logic             alloc,
  output logic             done,
  output logic [WIDTH-1:0] value
);

  logic [SLOT_CTRL_W-1:0] ctrl_r;
  logic [WIDTH-1:0]       value_r;

  // Slot state; a retiring slot ignores a same-cycle completion.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      ctrl_r  <= {SLOT_CTRL_W{1'b0}};
      value_r <= {WIDTH{1'b0}};
    end else if (flush) begin
      ctrl_r  <= {SLOT_CTRL_W{1'b0}};
    end else if (alloc_set) begin
      ctrl_r[SLOT_ALLOC_BIT] <= 1'b1;
      ctrl_r[SLOT_DONE_BIT]  <= 1'b0;
      value_r                <= push_value;
    end else if (free) begin
      ctrl_r  <= {SLOT_CTRL_W{1'b0}};
    end else if (upd_hit) begin
      ctrl_r[SLOT_DONE_BIT]  <= 1'b1;
      value_r                <= upd_value;
    end
  end

  assign alloc = ctrl_r[SLOT_ALLOC_BIT];
  assign done  = ctrl_r[SLOT_DONE_BIT];
  assign value = value_r;

endmodule

// File: rtl/status_valid_queue.sv
// In-order allocate / out-of-order complete / in-order retire status queue.
module status_valid_queue
  import status_valid_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 1
) (
  input logic                clk_i,
  input logic                rsn_i,
  status_valid_queue_if.slave bus
);

  localparam int unsigned AW = sv_clog2(DEPTH);

  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;
  logic             upd_err_r;

  logic             full_s;
  logic             empty_s;
  logic             valid_s;
  logic             push_acc_s;
  logic             pull_acc_s;
  logic             upd_miss_s;

  logic             alloc_s     [DEPTH];
  logic             done_s      [DEPTH];
  logic [WIDTH-1:0] value_s     [DEPTH];
  logic             alloc_set_s [DEPTH];
  logic             free_s      [DEPTH];
  logic             upd_hit_s   [DEPTH];

  // Accept decisions and per-slot strobes, all from pre-edge state.
  always_comb begin
    full_s     = (count_r == (AW+1)'(DEPTH));
    empty_s    = (count_r == {(AW+1){1'b0}});
    valid_s    = alloc_s[head_r] & done_s[head_r];
    push_acc_s = bus.push_i & ~full_s & ~bus.flush_i;
    pull_acc_s = bus.pull_i & valid_s & ~bus.flush_i;
    upd_miss_s = bus.upd_i & ~bus.flush_i & ~alloc_s[bus.upd_tag_i];
    for (int i = 0; i < DEPTH; i++) begin
      alloc_set_s[i] = push_acc_s & (tail_r == AW'(i));
      free_s[i]      = pull_acc_s & (head_r == AW'(i));
      upd_hit_s[i]   = bus.upd_i & (bus.upd_tag_i == AW'(i)) & alloc_s[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    status_valid_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i      (clk_i),
      .rsn_i      (rsn_i),
      .alloc_set  (alloc_set_s[g]),
      .free       (free_s[g]),
      .upd_hit    (upd_hit_s[g]),
      .push_value (bus.push_value_i),
      .upd_value  (bus.upd_value_i),
      .flush      (bus.flush_i),
      .alloc      (alloc_s[g]),
      .done       (done_s[g]),
      .value      (value_s[g])
    );
  end

  // Pointers, occupancy and the one-cycle update error flag.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head_r    <= {AW{1'b0}};
      tail_r    <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
      upd_err_r <= 1'b0;
    end else begin
      upd_err_r <= upd_miss_s;
      if (bus.flush_i) begin
        head_r  <= {AW{1'b0}};
        tail_r  <= {AW{1'b0}};
        count_r <= {(AW+1){1'b0}};
      end else begin
        if (push_acc_s) tail_r <= tail_r + AW'(1'b1);
        if (pull_acc_s) head_r <= head_r + AW'(1'b1);
        count_r <= count_r + (AW+1)'(push_acc_s) - (AW+1)'(pull_acc_s);
      end
    end
  end

  assign bus.alloc_tag_o  = tail_r;
  assign bus.upd_err_o    = upd_err_r;
  assign bus.valid_o      = valid_s;
  assign bus.head_value_o = value_s[head_r];
  assign bus.full_o       = full_s;
  assign bus.empty_o      = empty_s;
  assign bus.count_o      = count_r;

endmodule

// File: tb/tb_status_valid_queue.sv
// Scoreboard bench for status_valid_queue: directed scenarios plus random traffic
// against a list-of-entries reference model.
module tb_status_valid_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 2;

  typedef struct {
    int       tag;
    bit       done;
    logic [7:0] value;
  } entry_t;

  logic clk_i;
  logic rsn_i;

  status_valid_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

  status_valid_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .bus   (bus)
  );

  entry_t     mq[$];
  logic [7:0] sb_q[$];
  int         next_tag;
  bit         exp_err;
  int         n_checks;
  int         n_errors;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_tag(input int t);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].tag == t) return i;
    end
    return -1;
  endfunction

  task automatic check_status();
    bit mvalid;
    mvalid = (mq.size() > 0) && mq[0].done;
    check("count", 32'(bus.count_o), 32'(mq.size()));
    check("full", 32'(bus.full_o), 32'(mq.size() == DEPTH));
    check("empty", 32'(bus.empty_o), 32'(mq.size() == 0));
    check("alloc_tag", 32'(bus.alloc_tag_o), 32'(next_tag));
    check("valid", 32'(bus.valid_o), 32'(mvalid));
    check("upd_err", 32'(bus.upd_err_o), 32'(exp_err));
    if (mvalid) check("head_value", 32'(bus.head_value_o), 32'(mq[0].value));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input bit push, input logic [7:0] pv, input bit upd, input int tag,
                      input logic [7:0] uv, input bit pull, input bit flush);
    bit pull_ok, push_ok;
    int idx;
    entry_t e;
    bus.push_i       = push;
    bus.push_value_i = pv;
    bus.upd_i        = upd;
    bus.upd_tag_i    = AW'(tag);
    bus.upd_value_i  = uv;
    bus.pull_i       = pull;
    bus.flush_i      = flush;
    if (flush) begin
      mq.delete();
      next_tag = 0;
      exp_err  = 1'b0;
    end else begin
      pull_ok = (mq.size() > 0) && mq[0].done && pull;
      push_ok = (mq.size() < DEPTH) && push;
      idx     = find_tag(tag);
      exp_err = upd && (idx < 0);
      if (pull_ok) sb_q.push_back(mq[0].value);
      if (upd && idx >= 0) begin
        mq[idx].done  = 1'b1;
        mq[idx].value = uv;
      end
      if (pull_ok) void'(mq.pop_front());
      if (push_ok) begin
        e.tag = next_tag; e.done = 1'b0; e.value = pv;
        mq.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    @(posedge clk_i);
    #1;
    check_status();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset dropped in the middle of a cycle.
  task automatic mid_reset();
    bus.push_i = 1'b0; bus.upd_i = 1'b0; bus.pull_i = 1'b0; bus.flush_i = 1'b0;
    #2 rsn_i = 1'b0;
    mq.delete(); sb_q.delete(); next_tag = 0; exp_err = 1'b0;
    #1;
    check_status();
    check("rst_head_value", 32'(bus.head_value_o), 32'd0);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    idle();
  endtask

  // Retire monitor: every accepted pull must match the oldest expected value.
  always @(negedge clk_i) begin
    logic [7:0] ev;
    if (rsn_i === 1'b1 && bus.pull_i === 1'b1 && bus.valid_o === 1'b1 && bus.flush_i === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL retire: got %0h expected no retirement at %0t", bus.head_value_o, $time);
      end else begin
        ev = sb_q.pop_front();
        check("retire_value", 32'(bus.head_value_o), 32'(ev));
      end
    end
  end

  initial begin
    int t;
    n_checks = 0; n_errors = 0; next_tag = 0; exp_err = 1'b0;
    rsn_i = 1'b0;
    bus.push_i = 1'b0; bus.push_value_i = 8'h00; bus.upd_i = 1'b0; bus.upd_tag_i = 2'd0;
    bus.upd_value_i = 8'h00; bus.pull_i = 1'b0; bus.flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_status();
    check("rst_head_value", 32'(bus.head_value_o), 32'd0);
    rsn_i = 1'b1;
    idle();

    // Fill, then overflow push.
    step(1'b1, 8'h11, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    check("full_after_4", 32'(bus.full_o), 32'd1);
    step(1'b1, 8'h55, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    check("count_overflow", 32'(bus.count_o), 32'd4);

    // Out-of-order completion.
    step(1'b0, 8'h00, 1'b1, 2, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 0, 8'hA0, 1'b0, 1'b0);
    check("head_A0", 32'(bus.head_value_o), 32'hA0);
    step(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1, 8'hB1, 1'b0, 1'b0);
    check("head_B1", 32'(bus.head_value_o), 32'hB1);

    // Push+pull mid-occupancy, update to a free slot, update to a retiring head.
    step(1'b1, 8'h55, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1, 8'hEE, 1'b0, 1'b0);
    check("err_pulse", 32'(bus.upd_err_o), 32'd1);
    idle();
    step(1'b0, 8'h00, 1'b1, 2, 8'h99, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 2, 8'h98, 1'b0, 1'b0);

    // Full with a completed head: push+pull keeps push out.
    step(1'b1, 8'h66, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 3, 8'hD3, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    check("full_pushpull_count", 32'(bus.count_o), 32'd3);

    // Update to the tail slot in its push cycle.
    step(1'b1, 8'h5A, 1'b1, 3, 8'hA5, 1'b0, 1'b0);

    // Flush with entries outstanding, including an update in the flush cycle.
    step(1'b0, 8'h00, 1'b1, 0, 8'h12, 1'b0, 1'b1);
    step(1'b1, 8'h01, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b1);

    // Wrap-around: push, complete the previous push, retire the head.
    step(1'b1, 8'h20, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b1, (i - 1) % DEPTH, 8'(8'h80 + i), 1'b1, 1'b0);
    end

    // Random traffic with a mid-burst asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        mid_reset();
      end else begin
        if (mq.size() > 0 && $urandom_range(3) != 0)
          t = mq[$urandom_range(mq.size() - 1)].tag;
        else
          t = int'($urandom_range(DEPTH - 1));
        step(1'($urandom), 8'($urandom), 1'($urandom_range(3) != 0), t, 8'($urandom),
             1'($urandom), 1'($urandom_range(63) == 0));
      end
    end

    check("sb_final", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
